crypto_run_sequencer: RTL

//  Control-side sequencer for the target crypto core (load/busy handshake) on the crypto clock domain.
//  - Takes a start pulse from the register block.
//  - Waits a programmable pre-load delay, then issues core load pulses for a programmable number of runs.
//  - Drives the scope trigger and measures the core's busy latency for each run.
//  - Detects a hung core with a timeout.

---
 rtl/crypto_run_sequencer_if.sv | 29 ++
 rtl/crypto_run_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/crypto_run_sequencer_if.sv
// Handshake/config bundle between the register block, the crypto run sequencer and the target core.
interface crypto_run_sequencer_if #(
    parameter int pCNT_WIDTH = 16,
    parameter int pREP_WIDTH = 8
) ();
    logic                  start_i;
    logic                  abort_i;
    logic [pCNT_WIDTH-1:0] cfg_delay_i;
    logic [pREP_WIDTH-1:0] cfg_repeat_i;
    logic [pCNT_WIDTH-1:0] cfg_gap_i;
    logic                  core_load_o;
    logic                  core_busy_i;
    logic                  trigger_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  timeout_o;
    logic [pREP_WIDTH-1:0] runs_done_o;
    logic [pCNT_WIDTH-1:0] last_latency_o;

    modport master (
        output start_i, abort_i, cfg_delay_i, cfg_repeat_i, cfg_gap_i, core_busy_i,
        input  core_load_o, trigger_o, busy_o, done_o, timeout_o, runs_done_o, last_latency_o
    );

    modport slave (
        input  start_i, abort_i, cfg_delay_i, cfg_repeat_i, cfg_gap_i, core_busy_i,
        output core_load_o, trigger_o, busy_o, done_o, timeout_o, runs_done_o, last_latency_o
    );
endinterface

// File: rtl/crypto_run_sequencer.sv
// Crypto core run sequencer: pre-load delay, repeated load/busy runs with latency capture,
// per-run hang detection, abort and one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for start; config latched on start
// ARM   | counting down the pre-load delay
// LOAD  | one-cycle load strobe to the core
// WAIT  | waiting for core busy to rise (timeout guarded)
// RUN   | core busy; measuring latency (timeout guarded)
// GAP   | idle cycles between runs
// DONE  | one-cycle completion pulse
module crypto_run_sequencer #(
    parameter int pCNT_WIDTH = 16,
    parameter int pREP_WIDTH = 8,
    parameter int pTIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    crypto_run_sequencer_if.slave  bus
);
    localparam int                TO_W     = $clog2(pTIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(pTIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_LOAD, ST_WAIT, ST_RUN, ST_GAP, ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [pCNT_WIDTH-1:0] gap_q, gap_d;
    logic [pREP_WIDTH-1:0] rep_q, rep_d;
    logic [TO_W-1:0]       tcnt_q, tcnt_d;
    logic [pCNT_WIDTH-1:0] lat_q, lat_d;
    logic [pCNT_WIDTH-1:0] last_lat_q, last_lat_d;
    logic [pREP_WIDTH-1:0] runs_q, runs_d;
    logic [pREP_WIDTH-1:0] runs_inc;
    logic                  timeout_q, timeout_d;
    logic                  trigger_q;

    assign runs_inc = runs_q + pREP_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            rep_q      <= '0;
            tcnt_q     <= '0;
            lat_q      <= '0;
            last_lat_q <= '0;
            runs_q     <= '0;
            timeout_q  <= 1'b0;
            trigger_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rep_q      <= rep_d;
            tcnt_q     <= tcnt_d;
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
            runs_q     <= runs_d;
            timeout_q  <= timeout_d;
            trigger_q  <= (state_d == ST_LOAD) || (state_d == ST_WAIT) || (state_d == ST_RUN);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rep_d      = rep_q;
        tcnt_d     = tcnt_q;
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        runs_d     = runs_q;
        timeout_d  = timeout_q;

        // DONE is excluded so an abort held high cannot stretch the done pulse
        if (bus.abort_i && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_d   = ST_ARM;
                        cnt_d     = bus.cfg_delay_i;
                        gap_d     = bus.cfg_gap_i;
                        rep_d     = (bus.cfg_repeat_i == '0) ? pREP_WIDTH'(1) : bus.cfg_repeat_i;
                        runs_d    = '0;
                        timeout_d = 1'b0;
                    end
                end
                ST_ARM, ST_GAP: begin
                    if (cnt_q == '0) state_d = ST_LOAD;
                    else             cnt_d   = cnt_q - pCNT_WIDTH'(1);
                end
                ST_LOAD: begin
                    tcnt_d  = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.core_busy_i) begin
                        state_d = ST_RUN;
                        lat_d   = pCNT_WIDTH'(1);
                        tcnt_d  = '0;
                    end else if (tcnt_q == TO_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        tcnt_d = tcnt_q + TO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.core_busy_i) begin
                        if (tcnt_q == TO_LIMIT) begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            tcnt_d = tcnt_q + TO_W'(1);
                            if (lat_q != '1) lat_d = lat_q + pCNT_WIDTH'(1);
                        end
                    end else begin
                        last_lat_d = lat_q;
                        runs_d     = runs_inc;
                        if (runs_inc == rep_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = gap_q;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.core_load_o    = (state_q == ST_LOAD);
    assign bus.done_o         = (state_q == ST_DONE);
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.trigger_o      = trigger_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.runs_done_o    = runs_q;
    assign bus.last_latency_o = last_lat_q;
endmodule
